idwt_frame_ctrl: RTL

// Sequencer for one idwt_core instance. Generates the core's iclk_ena/iclk_enax2

---
 rtl/idwt_frame_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/idwt_frame_ctrl.sv
// Frame sequencer for one idwt_core: generates the core clock-enable strobes,
// feeds one L/H pair per iclk_ena slot and counts reconstructed samples.
module idwt_frame_ctrl #(
    parameter int pWIDTH    = 16,
    parameter int pDIV_LOG2 = 4,
    parameter int pLEN_W    = 16,
    parameter int pDRAIN    = 32
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              istart,
    input  logic [pLEN_W-1:0] ilen,
    input  logic              ival,
    input  logic [pWIDTH-1:0] idatL,
    input  logic [pWIDTH-1:0] idatH,
    output logic              ordy,
    output logic              ocore_clk_ena,
    output logic              ocore_clk_enax2,
    output logic              ocore_ena,
    output logic [pWIDTH-1:0] ocore_datL,
    output logic [pWIDTH-1:0] ocore_datH,
    input  logic              icore_oena,
    output logic              obusy,
    output logic              odone,
    output logic              oerr,
    output logic              ounderrun,
    output logic [pLEN_W:0]   ocnt_out
);

    localparam int DRAIN_W = $clog2(pDRAIN + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [pDIV_LOG2-1:0]  div_q;
    logic                  clk_ena_q, enax2_q;
    logic [pWIDTH-1:0]     hold_l_q, hold_l_d, hold_h_q, hold_h_d;
    logic                  hold_full_q, hold_full_d;
    logic [pLEN_W-1:0]     n_q, n_d, in_cnt_q, in_cnt_d;
    logic                  core_ena_q, core_ena_d;
    logic [pWIDTH-1:0]     dat_l_q, dat_l_d, dat_h_q, dat_h_d;
    logic                  underrun_q, underrun_d;
    logic [pLEN_W:0]       ocnt_q, ocnt_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic                  done_q, done_d, err_q, err_d;
    logic                  accept, consume;
    logic [pLEN_W:0]       two_n;

    // Free-running divider; the strobes are registered so the core sees clean pulses.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            div_q     <= '0;
            clk_ena_q <= 1'b0;
            enax2_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            div_q     <= div_q + 1'b1;
            clk_ena_q <= &div_q;
            enax2_q   <= &div_q[pDIV_LOG2-2:0];
        end
    end

    assign ordy    = (state_q == FEED) && !hold_full_q;
    assign accept  = ival && ordy;
    assign consume = (state_q == FEED) && clk_ena_q && hold_full_q;
    assign two_n   = {n_q, 1'b0};

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d     = state_q;
        hold_l_d    = hold_l_q;
        hold_h_d    = hold_h_q;
        hold_full_d = (hold_full_q && !consume) || accept;
        n_d         = n_q;
        in_cnt_d    = in_cnt_q;
        core_ena_d  = core_ena_q;
        dat_l_d     = dat_l_q;
        dat_h_d     = dat_h_q;
        underrun_d  = underrun_q;
        ocnt_d      = ocnt_q;
        drain_d     = drain_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (accept) begin
            hold_l_d = idatL;
            hold_h_d = idatH;
        end

        if (state_q != IDLE && enax2_q && icore_oena && ocnt_q != '1)
            ocnt_d = ocnt_q + 1'b1;

        // Outside FEED the core must not keep re-sampling a stale pair.
        if (clk_ena_q && state_q != FEED)
            core_ena_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (istart) begin
                    if (ilen == '0) begin
                        done_d = 1'b1;
                    end else begin
                        n_d        = ilen;
                        in_cnt_d   = '0;
                        ocnt_d     = '0;
                        underrun_d = 1'b0;
                        drain_d    = '0;
                        state_d    = FEED;
                    end
                end
            end
            FEED: begin
                if (clk_ena_q) begin
                    if (hold_full_q) begin
                        core_ena_d = 1'b1;
                        dat_l_d    = hold_l_q;
                        dat_h_d    = hold_h_q;
                        in_cnt_d   = in_cnt_q + 1'b1;
                        if (in_cnt_d == n_q)
                            state_d = DRAIN;
                    end else begin
                        core_ena_d = 1'b0;
                        underrun_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (ocnt_q == two_n) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (drain_q == DRAIN_W'(pDRAIN)) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (clk_ena_q) begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            // NOTE: datapath registers are reset too, so every output reads 0 out of reset.
            state_q     <= IDLE;
            hold_l_q    <= '0;
            hold_h_q    <= '0;
            hold_full_q <= 1'b0;
            n_q         <= '0;
            in_cnt_q    <= '0;
            core_ena_q  <= 1'b0;
            dat_l_q     <= '0;
            dat_h_q     <= '0;
            underrun_q  <= 1'b0;
            ocnt_q      <= '0;
            drain_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_l_q    <= hold_l_d;
            hold_h_q    <= hold_h_d;
            hold_full_q <= hold_full_d;
            n_q         <= n_d;
            in_cnt_q    <= in_cnt_d;
            core_ena_q  <= core_ena_d;
            dat_l_q     <= dat_l_d;
            dat_h_q     <= dat_h_d;
            underrun_q  <= underrun_d;
            ocnt_q      <= ocnt_d;
            drain_q     <= drain_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ocore_clk_ena   = clk_ena_q;
    assign ocore_clk_enax2 = enax2_q;
    assign ocore_ena       = core_ena_q;
    assign ocore_datL      = dat_l_q;
    assign ocore_datH      = dat_h_q;
    assign obusy           = (state_q != IDLE);
    assign odone           = done_q;
    assign oerr            = err_q;
    assign ounderrun       = underrun_q;
    assign ocnt_out        = ocnt_q;

endmodule
